// File: rtl/iram_loader.sv
// Boot-time program loader: parses SYNC/LEN/DATA/CSUM byte frames, writes
// little-endian words into instruction RAM and releases the core on a good frame.
module iram_loader #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] ADDR_BASE = 32'h0000_0000,
  parameter int              MAX_WORDS = 4096,
  parameter logic [7:0]      SYNC_BYTE = 8'hA5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [7:0]      rx_data_i,
  input  logic            rx_valid_i,
  output logic            rx_ready_o,
  input  logic            cpu_fault_i,
  output logic            iram_wr_en_o,
  output logic [XLEN-1:0] iram_wr_addr_o,
  output logic [XLEN-1:0] iram_wr_data_o,
  output logic            cpu_rst_n_o,
  output logic            load_done_o,
  output logic            load_err_o,
  output logic [15:0]     words_loaded_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_CSUM,
    ST_RUN,
    ST_ERROR
  } state_t;

  state_t            state_reg, state_next;
  logic [15:0]       len_reg, len_next;
  logic [1:0]        byte_idx_reg, byte_idx_next;
  logic [31:0]       word_buf_reg, word_buf_next;
  logic [7:0]        csum_reg, csum_next;
  logic              wr_en_reg, wr_en_next;
  logic [XLEN-1:0]   wr_addr_reg, wr_addr_next;
  logic [XLEN-1:0]   wr_data_reg, wr_data_next;
  logic [15:0]       words_reg, words_next;
  logic              cpu_rst_n_reg, load_done_reg, load_err_reg;

  logic              rx_accept;
  logic              is_sync;
  logic [15:0]       len_full;
  logic [31:0]       word_assembled;

  // The only back-pressure is the one-cycle bubble while a word is written.
  assign rx_ready_o = ~wr_en_reg;
  assign rx_accept  = rx_valid_i & rx_ready_o;
  assign is_sync    = (rx_data_i == SYNC_BYTE);
  assign len_full   = {rx_data_i, len_reg[7:0]};

  // Incoming data byte lands in lane byte_idx; the other lanes keep their contents.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic lane_hit;
    assign lane_hit = rx_accept && (state_reg == ST_DATA) && (byte_idx_reg == 2'(gi));
    assign word_assembled[gi*8 +: 8] = lane_hit ? rx_data_i : word_buf_reg[gi*8 +: 8];
  end

  always_comb begin
    state_next    = state_reg;
    len_next      = len_reg;
    byte_idx_next = byte_idx_reg;
    word_buf_next = word_buf_reg;
    csum_next     = csum_reg;
    wr_en_next    = 1'b0;
    wr_addr_next  = wr_addr_reg;
    wr_data_next  = wr_data_reg;
    words_next    = words_reg;

    if (state_reg == ST_RUN && cpu_fault_i) begin
      state_next = ST_IDLE;
    end else if (rx_accept) begin
      case (state_reg)
        ST_IDLE, ST_RUN, ST_ERROR: begin
          if (is_sync) begin
            state_next    = ST_LEN0;
            words_next    = 16'd0;
            csum_next     = 8'd0;
            byte_idx_next = 2'd0;
          end
        end
        ST_LEN0: begin
          len_next   = {8'h00, rx_data_i};
          state_next = ST_LEN1;
        end
        ST_LEN1: begin
          len_next = len_full;
          if (int'(len_full) > MAX_WORDS)
            state_next = ST_ERROR;
          else if (len_full == 16'd0)
            state_next = ST_CSUM;
          else
            state_next = ST_DATA;
        end
        ST_DATA: begin
          word_buf_next = word_assembled;
          csum_next     = csum_reg ^ rx_data_i;
          byte_idx_next = byte_idx_reg + 2'd1;
          if (byte_idx_reg == 2'd3) begin
            wr_en_next   = 1'b1;
            wr_data_next = XLEN'(word_assembled);
            wr_addr_next = ADDR_BASE + XLEN'({words_reg, 2'b00});
            words_next   = words_reg + 16'd1;
            if (words_reg + 16'd1 == len_reg)
              state_next = ST_CSUM;
          end
        end
        ST_CSUM: begin
          state_next = (rx_data_i == csum_reg) ? ST_RUN : ST_ERROR;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= ST_IDLE;
      len_reg       <= 16'd0;
      byte_idx_reg  <= 2'd0;
      word_buf_reg  <= 32'd0;
      csum_reg      <= 8'd0;
      wr_en_reg     <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
      words_reg     <= 16'd0;
      cpu_rst_n_reg <= 1'b0;
      load_done_reg <= 1'b0;
      load_err_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      len_reg       <= len_next;
      byte_idx_reg  <= byte_idx_next;
      word_buf_reg  <= word_buf_next;
      csum_reg      <= csum_next;
      wr_en_reg     <= wr_en_next;
      wr_addr_reg   <= wr_addr_next;
      wr_data_reg   <= wr_data_next;
      words_reg     <= words_next;
      // Status flags track the state being entered, so they change with it.
      cpu_rst_n_reg <= (state_next == ST_RUN);
      load_done_reg <= (state_next == ST_RUN);
      load_err_reg  <= (state_next == ST_ERROR);
    end
  end

  assign iram_wr_en_o   = wr_en_reg;
  assign iram_wr_addr_o = wr_addr_reg;
  assign iram_wr_data_o = wr_data_reg;
  assign cpu_rst_n_o    = cpu_rst_n_reg;
  assign load_done_o    = load_done_reg;
  assign load_err_o     = load_err_reg;
  assign words_loaded_o = words_reg;

endmodule

// File: tb/tb_iram_loader.sv
// Self-checking bench for iram_loader: frame table, hand-written corner
// sequences and random frames against a frame-level reference model.
module tb_iram_loader;

  localparam int          MAX_WORDS = 4096;
  localparam logic [31:0] ADDR_BASE = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic        cpu_fault_i;
  logic        iram_wr_en_o;
  logic [31:0] iram_wr_addr_o;
  logic [31:0] iram_wr_data_o;
  logic        cpu_rst_n_o;
  logic        load_done_o;
  logic        load_err_o;
  logic [15:0] words_loaded_o;

  always #5 clk_i = ~clk_i;

  iram_loader dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .rx_data_i     (rx_data_i),
    .rx_valid_i    (rx_valid_i),
    .rx_ready_o    (rx_ready_o),
    .cpu_fault_i   (cpu_fault_i),
    .iram_wr_en_o  (iram_wr_en_o),
    .iram_wr_addr_o(iram_wr_addr_o),
    .iram_wr_data_o(iram_wr_data_o),
    .cpu_rst_n_o   (cpu_rst_n_o),
    .load_done_o   (load_done_o),
    .load_err_o    (load_err_o),
    .words_loaded_o(words_loaded_o)
  );

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef logic [7:0] byte_q_t[$];
  typedef struct { int n; bit bad; bit hold; bit exp_done; bit exp_err; int exp_words; } vec_t;

  int   tests = 0;
  int   fails = 0;
  wr_t  exp_wr_q[$];
  wr_t  mon_e;
  logic last_wr_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    end
  endtask

  // Write monitor: every IRAM write must match the next word the model expects.
  always @(negedge clk_i) begin
    if (!rst_i && iram_wr_en_o) begin
      check("wr_ready_bubble", {31'd0, rx_ready_o}, 32'd0);
      check("wr_single_pulse", {31'd0, last_wr_en}, 32'd0);
      if (exp_wr_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write required",
                 iram_wr_addr_o, iram_wr_data_o);
      end else begin
        mon_e = exp_wr_q.pop_front();
        check("wr_addr", iram_wr_addr_o, mon_e.addr);
        check("wr_data", iram_wr_data_o, mon_e.data);
      end
    end
    last_wr_en = iram_wr_en_o;
  end

  task automatic send_byte(input logic [7:0] b, input bit hold);
    int guard = 0;
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    while (!rx_ready_o && guard < 8) begin
      @(negedge clk_i);
      guard++;
    end
    if (!rx_ready_o) begin
      tests++;
      fails++;
      $display("FAIL rx_ready_timeout: ready 0 after %0d cycles, required 1", guard);
    end
    @(negedge clk_i);
    if (!hold) begin
      rx_valid_i = 1'b0;
      @(negedge clk_i);
    end
  endtask

  task automatic send_q(input byte_q_t q, input bit hold);
    foreach (q[i]) send_byte(q[i], hold);
    rx_valid_i = 1'b0;
  endtask

  // Reference model: a frame of N words loads iff N <= MAX_WORDS, and is
  // accepted iff its trailing byte equals the XOR of all data bytes.
  task automatic send_frame(input int n, input bit bad, input bit hold,
                            output bit exp_done, output bit exp_err, output int exp_words);
    byte_q_t     q;
    logic [7:0]  cs = 8'd0;
    logic [7:0]  b;
    logic [15:0] n16;
    logic [31:0] w;
    n16 = n[15:0];
    q = {8'hA5, n16[7:0], n16[15:8]};
    if (n > MAX_WORDS) begin
      for (int i = 0; i < 6; i++) q.push_back(8'($urandom_range(0, 127)));
      exp_done = 1'b0; exp_err = 1'b1; exp_words = 0;
    end else begin
      for (int i = 0; i < n; i++) begin
        w = 32'd0;
        for (int k = 0; k < 4; k++) begin
          b = 8'($urandom);
          q.push_back(b);
          cs ^= b;
          w |= 32'(b) << (8 * k);
        end
        exp_wr_q.push_back('{ADDR_BASE + 32'(4 * i), w});
      end
      if (bad) cs ^= 8'h01 << $urandom_range(0, 7);
      q.push_back(cs);
      exp_done = !bad; exp_err = bad; exp_words = n;
    end
    $display("[TB] frame n=%0d bad_csum=%0d hold_valid=%0d bytes=%0d", n, bad, hold, q.size());
    send_q(q, hold);
    repeat (2) @(negedge clk_i);
    check("wr_all_issued", exp_wr_q.size(), 0);
    exp_wr_q.delete();
  endtask

  task automatic check_outputs(input string tag, input bit done, input bit err, input int words);
    check({tag, "_done"},    {31'd0, load_done_o}, {31'd0, done});
    check({tag, "_err"},     {31'd0, load_err_o},  {31'd0, err});
    check({tag, "_cpu_rst"}, {31'd0, cpu_rst_n_o}, {31'd0, done});
    check({tag, "_words"},   {16'd0, words_loaded_o}, 32'(words));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"},   {31'd0, rx_ready_o},   32'd1);
    check({tag, "_wr_en"},   {31'd0, iram_wr_en_o}, 32'd0);
    check({tag, "_wr_addr"}, iram_wr_addr_o,        32'd0);
    check({tag, "_wr_data"}, iram_wr_data_o,        32'd0);
    check_outputs(tag, 1'b0, 1'b0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t    vecs[7];
    byte_q_t good, badf;
    bit      d, e;
    int      wc;

    rst_i = 1'b1; rx_valid_i = 1'b0; rx_data_i = 8'h00; cpu_fault_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check_reset_values("reset");
    rst_i = 1'b0;
    @(negedge clk_i);

    // Two-word frame with correct checksum.
    good = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7C};
    exp_wr_q.push_back('{32'h0, 32'h0000_0013});
    exp_wr_q.push_back('{32'h4, 32'h0000_006F});
    $display("[TB] frame fixed two-word good");
    send_q(good, 1'b0);
    repeat (2) @(negedge clk_i);
    check("fixed_wr_issued", exp_wr_q.size(), 0);
    check_outputs("fixed_good", 1'b1, 1'b0, 2);
    check("hold_addr", iram_wr_addr_o, 32'h4);
    check("hold_data", iram_wr_data_o, 32'h0000_006F);

    // Same frame, wrong checksum: writes still happen, then error.
    badf = good;
    badf[11] = 8'h7D;
    exp_wr_q.push_back('{32'h0, 32'h0000_0013});
    exp_wr_q.push_back('{32'h4, 32'h0000_006F});
    $display("[TB] frame fixed two-word bad checksum");
    send_q(badf, 1'b0);
    repeat (2) @(negedge clk_i);
    check("bad_wr_issued", exp_wr_q.size(), 0);
    check_outputs("fixed_bad", 1'b0, 1'b1, 2);
    exp_wr_q.push_back('{32'h0, 32'h0000_0013});
    exp_wr_q.push_back('{32'h4, 32'h0000_006F});
    $display("[TB] frame fixed two-word good after error");
    send_q(good, 1'b0);
    repeat (2) @(negedge clk_i);
    check_outputs("recover", 1'b1, 1'b0, 2);

    // Oversized length: error right after LEN_HI, data bytes ignored.
    $display("[TB] frame oversize header");
    send_q({8'hA5, 8'h01, 8'h10}, 1'b0);
    check("oversize_err_now", {31'd0, load_err_o}, 32'd1);
    send_q({8'h13, 8'h00, 8'h00, 8'h00, 8'h7C}, 1'b0);
    repeat (2) @(negedge clk_i);
    check_outputs("oversize", 1'b0, 1'b1, 0);

    // Zero-length frame, then junk in RUN.
    $display("[TB] frame zero-length");
    send_q({8'hA5, 8'h00, 8'h00, 8'h00}, 1'b0);
    check_outputs("zero_len", 1'b1, 1'b0, 0);
    send_q({8'h11, 8'h22}, 1'b0);
    repeat (2) @(negedge clk_i);
    check_outputs("run_junk", 1'b1, 1'b0, 0);

    // Core fault in RUN drops back to IDLE.
    $display("[TB] fault pulse in RUN");
    cpu_fault_i = 1'b1;
    @(negedge clk_i);
    cpu_fault_i = 1'b0;
    check("fault_cpu_rst", {31'd0, cpu_rst_n_o}, 32'd0);
    check("fault_done",    {31'd0, load_done_o}, 32'd0);
    send_q({8'h00}, 1'b0);
    check("idle_ignores", {31'd0, load_done_o}, 32'd0);

    // Reset in the middle of word 0.
    $display("[TB] reset mid-word");
    send_q({8'hA5, 8'h02, 8'h00, 8'h13, 8'h00}, 1'b0);
    rst_i = 1'b1;
    @(negedge clk_i);
    check_reset_values("midreset");
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    exp_wr_q.push_back('{ADDR_BASE, 32'hDEAD_BEEF});
    $display("[TB] frame fresh after reset");
    send_q({8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22}, 1'b1);
    repeat (2) @(negedge clk_i);
    check("fresh_wr_issued", exp_wr_q.size(), 0);
    check_outputs("fresh", 1'b1, 1'b0, 1);

    // Table of frames with fixed expected outcome.
    vecs[0] = '{1,    1'b0, 1'b0, 1'b1, 1'b0, 1};
    vecs[1] = '{3,    1'b1, 1'b0, 1'b0, 1'b1, 3};
    vecs[2] = '{0,    1'b0, 1'b1, 1'b1, 1'b0, 0};
    vecs[3] = '{5,    1'b0, 1'b1, 1'b1, 1'b0, 5};
    vecs[4] = '{4097, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    vecs[5] = '{0,    1'b1, 1'b0, 1'b0, 1'b1, 0};
    vecs[6] = '{4096, 1'b0, 1'b1, 1'b1, 1'b0, 4096};
    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].n, vecs[i].bad, vecs[i].hold, d, e, wc);
      check_outputs("table", vecs[i].exp_done, vecs[i].exp_err, vecs[i].exp_words);
    end

    // Random frames checked against the model's outcome.
    for (int i = 0; i < 20; i++) begin
      send_frame($urandom_range(0, 6), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), d, e, wc);
      check_outputs("random", d, e, wc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
